// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizes, types and helpers for the reorder buffer
package reorder_buffer_pkg;
    localparam int ROB_SIZE  = 16;
    localparam int ROB_IDX_W = 4;
    localparam int REG_W     = 5;
    localparam int XLEN      = 32;

    typedef logic [ROB_IDX_W-1:0] rob_idx_t;
    typedef logic [REG_W-1:0]     reg_idx_t;
    typedef logic [XLEN-1:0]      word_t;

    typedef struct packed {
        logic     busy;
        logic     ready;
        reg_idx_t rd;
        word_t    val;
        logic     is_branch;
        logic     pred;
        logic     actual;
        word_t    pc;
    } rob_entry_t;

    function automatic rob_idx_t rob_next(input rob_idx_t i);
        return i + rob_idx_t'(1);
    endfunction

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch && (e.actual != e.pred);
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// rtl/reorder_buffer_if.sv - dispatch, CDB, commit, query and flush signals of the reorder buffer
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic     rdy;
    logic     issue_flag_in;
    reg_idx_t issue_rd_in;
    logic     issue_is_branch_in;
    logic     issue_pred_jump_in;
    logic     ROB_full_out;
    rob_idx_t issue_idx_out;
    logic     RF_new_flag_out;
    rob_idx_t RF_new_idx_out;
    reg_idx_t RF_new_rd_out;
    logic     RF_write_flag_out;
    rob_idx_t RF_write_idx_out;
    reg_idx_t RF_write_rd_out;
    word_t    RF_val_out;
    logic     cdb_flag_in;
    rob_idx_t cdb_idx_in;
    word_t    cdb_val_in;
    logic     cdb_jump_in;
    word_t    cdb_pc_in;
    rob_idx_t query_rs1_idx_in;
    rob_idx_t query_rs2_idx_in;
    logic     query_rs1_ready_out;
    logic     query_rs2_ready_out;
    word_t    query_rs1_val_out;
    word_t    query_rs2_val_out;
    logic     commit_flag_out;
    rob_idx_t commit_idx_out;
    logic     jump_wrong;
    word_t    jump_pc_out;

    modport slave (
        input  rdy, issue_flag_in, issue_rd_in, issue_is_branch_in, issue_pred_jump_in,
        input  cdb_flag_in, cdb_idx_in, cdb_val_in, cdb_jump_in, cdb_pc_in,
        input  query_rs1_idx_in, query_rs2_idx_in,
        output ROB_full_out, issue_idx_out, RF_new_flag_out, RF_new_idx_out, RF_new_rd_out,
        output RF_write_flag_out, RF_write_idx_out, RF_write_rd_out, RF_val_out,
        output query_rs1_ready_out, query_rs2_ready_out, query_rs1_val_out, query_rs2_val_out,
        output commit_flag_out, commit_idx_out, jump_wrong, jump_pc_out
    );

    modport master (
        output rdy, issue_flag_in, issue_rd_in, issue_is_branch_in, issue_pred_jump_in,
        output cdb_flag_in, cdb_idx_in, cdb_val_in, cdb_jump_in, cdb_pc_in,
        output query_rs1_idx_in, query_rs2_idx_in,
        input  ROB_full_out, issue_idx_out, RF_new_flag_out, RF_new_idx_out, RF_new_rd_out,
        input  RF_write_flag_out, RF_write_idx_out, RF_write_rd_out, RF_val_out,
        input  query_rs1_ready_out, query_rs2_ready_out, query_rs1_val_out, query_rs2_val_out,
        input  commit_flag_out, commit_idx_out, jump_wrong, jump_pc_out
    );
endinterface

// File: rtl/reorder_buffer_query.sv
// rtl/reorder_buffer_query.sv - one operand readiness lookup with same-cycle CDB bypass
module reorder_buffer_query
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_SIZE-1:0] i_busy,
    input  logic [ROB_SIZE-1:0] i_ready,
    input  word_t               i_val [ROB_SIZE],
    input  logic                i_cdb_flag,
    input  rob_idx_t            i_cdb_idx,
    input  word_t               i_cdb_val,
    input  rob_idx_t            i_idx,
    output logic                o_ready,
    output word_t               o_val
);
    logic w_bypass;

    assign w_bypass = i_cdb_flag && (i_cdb_idx == i_idx);
    assign o_ready  = w_bypass || (i_busy[i_idx] && i_ready[i_idx]);
    assign o_val    = w_bypass ? i_cdb_val : i_val[i_idx];
endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular ROB: rename on issue, CDB capture, in-order commit, mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    reorder_buffer_if.slave  bus
);
    rob_idx_t             r_head;
    rob_idx_t             r_tail;
    logic [ROB_IDX_W:0]   r_count;
    logic [ROB_SIZE-1:0]  r_busy;
    logic [ROB_SIZE-1:0]  r_ready;
    logic [ROB_SIZE-1:0]  r_is_branch;
    logic [ROB_SIZE-1:0]  r_pred;
    logic [ROB_SIZE-1:0]  r_actual;
    reg_idx_t             r_rd  [ROB_SIZE];
    word_t                r_val [ROB_SIZE];
    word_t                r_pc  [ROB_SIZE];

    logic     r_commit_flag;
    rob_idx_t r_commit_idx;
    logic     r_write_flag;
    rob_idx_t r_write_idx;
    reg_idx_t r_write_rd;
    word_t    r_write_val;
    logic     r_jump_wrong;
    word_t    r_jump_pc;

    logic       w_full;
    logic       w_accept;
    logic       w_cdb_we;
    logic       w_commit;
    rob_entry_t w_head;

    assign w_full   = (r_count == (ROB_IDX_W+1)'(ROB_SIZE));
    assign w_accept = bus.rdy && bus.issue_flag_in && !w_full && !r_jump_wrong;
    assign w_cdb_we = bus.rdy && bus.cdb_flag_in && !r_jump_wrong && r_busy[bus.cdb_idx_in];
    assign w_head   = '{busy: r_busy[r_head], ready: r_ready[r_head], rd: r_rd[r_head],
                        val: r_val[r_head], is_branch: r_is_branch[r_head], pred: r_pred[r_head],
                        actual: r_actual[r_head], pc: r_pc[r_head]};
    assign w_commit = bus.rdy && !r_jump_wrong && w_head.busy && w_head.ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_busy        <= '0;
            r_ready       <= '0;
            r_commit_flag <= 1'b0;
            r_commit_idx  <= '0;
            r_write_flag  <= 1'b0;
            r_write_idx   <= '0;
            r_write_rd    <= '0;
            r_write_val   <= '0;
            r_jump_wrong  <= 1'b0;
            r_jump_pc     <= '0;
        end else if (bus.rdy) begin
            if (r_jump_wrong) begin
                // Flush cycle: everything younger than the mispredicted branch is discarded.
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                r_busy        <= '0;
                r_ready       <= '0;
                r_commit_flag <= 1'b0;
                r_write_flag  <= 1'b0;
                r_jump_wrong  <= 1'b0;
            end else begin
                r_commit_flag <= w_commit;
                r_write_flag  <= w_commit;
                r_jump_wrong  <= w_commit && is_mispredict(w_head);
                r_count       <= r_count + (ROB_IDX_W+1)'(w_accept) - (ROB_IDX_W+1)'(w_commit);
                if (w_cdb_we) begin
                    r_ready[bus.cdb_idx_in] <= 1'b1;
                end
                if (w_commit) begin
                    r_commit_idx   <= r_head;
                    r_write_idx    <= r_head;
                    r_write_rd     <= w_head.rd;
                    r_write_val    <= w_head.val;
                    r_busy[r_head] <= 1'b0;
                    r_head         <= rob_next(r_head);
                    if (is_mispredict(w_head)) begin
                        r_jump_pc <= w_head.pc;
                    end
                end
                if (w_accept) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= rob_next(r_tail);
                end
            end
        end
    end

    // Payload needs no reset: it is only observed behind busy/ready.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rd[r_tail]        <= bus.issue_rd_in;
            r_is_branch[r_tail] <= bus.issue_is_branch_in;
            r_pred[r_tail]      <= bus.issue_pred_jump_in;
        end
        if (w_cdb_we) begin
            r_val[bus.cdb_idx_in]    <= bus.cdb_val_in;
            r_actual[bus.cdb_idx_in] <= bus.cdb_jump_in;
            r_pc[bus.cdb_idx_in]     <= bus.cdb_pc_in;
        end
    end

    reorder_buffer_query u_query_rs1 (
        .i_busy     (r_busy),
        .i_ready    (r_ready),
        .i_val      (r_val),
        .i_cdb_flag (bus.cdb_flag_in),
        .i_cdb_idx  (bus.cdb_idx_in),
        .i_cdb_val  (bus.cdb_val_in),
        .i_idx      (bus.query_rs1_idx_in),
        .o_ready    (bus.query_rs1_ready_out),
        .o_val      (bus.query_rs1_val_out)
    );

    reorder_buffer_query u_query_rs2 (
        .i_busy     (r_busy),
        .i_ready    (r_ready),
        .i_val      (r_val),
        .i_cdb_flag (bus.cdb_flag_in),
        .i_cdb_idx  (bus.cdb_idx_in),
        .i_cdb_val  (bus.cdb_val_in),
        .i_idx      (bus.query_rs2_idx_in),
        .o_ready    (bus.query_rs2_ready_out),
        .o_val      (bus.query_rs2_val_out)
    );

    assign bus.ROB_full_out      = w_full;
    assign bus.issue_idx_out     = r_tail;
    assign bus.RF_new_flag_out   = w_accept;
    assign bus.RF_new_idx_out    = r_tail;
    assign bus.RF_new_rd_out     = bus.issue_rd_in;
    assign bus.RF_write_flag_out = r_write_flag;
    assign bus.RF_write_idx_out  = r_write_idx;
    assign bus.RF_write_rd_out   = r_write_rd;
    assign bus.RF_val_out        = r_write_val;
    assign bus.commit_flag_out   = r_commit_flag;
    assign bus.commit_idx_out    = r_commit_idx;
    assign bus.jump_wrong        = r_jump_wrong;
    assign bus.jump_pc_out       = r_jump_pc;
endmodule
